// File: rtl/dsp_product_capture.sv
// dsp_product_capture: captures CAPTURE_LEN registered DSP products after a start into a FIFO read as 32-bit words.
// Optional DSP_CAPTURE_TIMESTAMP_EN appends a per-entry 32-bit cycle timestamp word.
module dsp_product_capture #(
  parameter int FIFO_DEPTH    = 8,
  parameter int SETTLE_CYCLES = 0,
  parameter int CAPTURE_LEN   = 6
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [63:0]                   product,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [31:0]                   rd_data,
  output logic                          rd_last,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef DSP_CAPTURE_TIMESTAMP_EN
  localparam int EW = 96;
  localparam logic [1:0] LAST_WORD = 2'd2;
`else
  localparam int EW = 64;
  localparam logic [1:0] LAST_WORD = 2'd1;
`endif
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;
  state_t          state_q, state_d;
  logic [7:0]      settle_q, settle_d, count_q, count_d;
  logic [63:0]     product_q;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   entry, head;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [1:0]      word_q, word_d;
  logic            overflow_q, overflow_d, busy_q, busy_d, done_q, done_d;
  logic [31:0]     hold_q, head_word;
  logic            push_req, push, pop, xfer, full;
`ifdef DSP_CAPTURE_TIMESTAMP_EN
  logic [31:0]     stamp_q, stamp_d;
  // stamp_d is the post-edge count, so the first SETTLE=0 sample reads 1
  assign stamp_d = (state_q == IDLE && start) ? 32'd0 : stamp_q + 32'd1;
  assign entry   = {stamp_d, product_q};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) stamp_q <= '0;
    else stamp_q <= stamp_d;
`else
  assign entry = product_q;
`endif
  assign head      = mem_q[rd_ptr_q];
  assign head_word = word_q == 2'd0 ? head[31:0] : word_q == 2'd1 ? head[63:32] : head[EW-1:EW-32];
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign level     = level_q;
  always_comb begin
    rd_valid   = level_q != '0;
    rd_data    = rd_valid ? head_word : hold_q;
    rd_last    = rd_valid && word_q == LAST_WORD;
    xfer       = rd_valid && rd_ready;
    pop        = xfer && word_q == LAST_WORD;
    full       = level_q == (AW+1)'(FIFO_DEPTH);
    push_req   = state_q == CAPTURE;
    push       = push_req && (!full || pop);
    overflow_d = (push_req && !push) ? 1'b1 : clr_overflow ? 1'b0 : overflow_q;
    word_d     = pop ? 2'd0 : xfer ? word_q + 2'd1 : word_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q + (AW+1)'(push) - (AW+1)'(pop);
    state_d    = state_q;
    settle_d   = settle_q;
    count_d    = count_q;
    if (state_q == IDLE && start) begin
      state_d  = SETTLE_CYCLES > 0 ? SETTLE : CAPTURE;
      settle_d = 8'(SETTLE_CYCLES);
      count_d  = 8'(CAPTURE_LEN);
    end else if (state_q == SETTLE) begin
      settle_d = settle_q - 8'd1;
      state_d  = settle_q == 8'd1 ? CAPTURE : SETTLE;
    end else if (state_q == CAPTURE) begin
      count_d  = count_q - 8'd1;
      state_d  = count_q == 8'd1 ? IDLE : CAPTURE;
    end
    busy_d = state_d != IDLE;
    done_d = state_d == CAPTURE && count_d == 8'd1;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      count_q    <= '0;
      product_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      word_q     <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      count_q    <= count_d;
      product_q  <= product;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      word_q     <= word_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hold_q     <= rd_data;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= entry;
endmodule

// File: doc/dsp_product_capture.md
Name: dsp_product_capture

Overview:
- Downstream capture stage for a MULT18X18 cascade. Records one 64-bit DSP product bus on consecutive cycles after a start event, so firmware can watch the operand propagate along the chain.
- Samples go into a small FIFO. A RISC-V peripheral drains the FIFO as 32-bit words, low word first, through a valid/ready port.

Parameters:
- FIFO_DEPTH, 8, number of 64-bit entries; power of two, 2..64.
- SETTLE_CYCLES, 0, cycles between the accepted start and the first sample; 0..255.
- CAPTURE_LEN, 6, number of consecutive samples per run; 1..255.

Ports:
- clk  in  1  single clock; DSP cascade and CPU share it.
- resetn  in  1  asynchronous, active-low reset.
- product  in  64  DSP DOUT bus being observed.
- start  in  1  single-cycle request to begin a run.
- busy  out  1  high while in SETTLE or CAPTURE.
- done  out  1  one-cycle pulse on the final sample cycle.
- overflow  out  1  sticky; a sample was dropped because the FIFO was full.
- clr_overflow  in  1  clears overflow.
- rd_valid  out  1  rd_data holds a valid word.
- rd_ready  in  1  consumer accepts the word.
- rd_data  out  32  current word.
- rd_last  out  1  current word is the final word of an entry.
- level  out  $clog2(FIFO_DEPTH)+1  number of entries held.

Behaviour:
- Reset (resetn=0, asynchronous): FSM=IDLE; all counters and FIFO pointers 0; word index 0. busy, done, overflow, rd_valid, rd_last, level all 0; rd_data 0.
- FSM IDLE:
  - start=1 -> SETTLE when SETTLE_CYCLES>0, otherwise straight to CAPTURE. The settle counter loads SETTLE_CYCLES; the sample counter loads CAPTURE_LEN.
  - start is ignored outside IDLE.
- FSM SETTLE: the counter decrements each cycle; at 1 -> CAPTURE. The first sample is taken exactly SETTLE_CYCLES+1 cycles after the start cycle. With SETTLE_CYCLES=0 it is taken on the cycle after start.
- FSM CAPTURE:
  - Each cycle, push the registered value of product into the FIFO and decrement the sample counter.
  - At count 1: done=1 for that cycle, then -> IDLE.
- FIFO full:
  - A push is accepted when not full, or when a pop completes in the same cycle.
  - Otherwise the sample is dropped, overflow is set, and the sample still counts toward CAPTURE_LEN.
  - When clr_overflow and a new overflow occur in the same cycle, set wins.
- FIFO empty: rd_valid=0; rd_data holds its last value. The first word of a pushed entry is visible with rd_valid=1 on the cycle after the push (1-cycle write-to-read latency).
- Read side:
  - Each entry is two words: word0 = product[31:0] (rd_last=0), word1 = product[63:32] (rd_last=1).
  - A word transfers when rd_valid and rd_ready are both 1.
  - The entry is popped, and level decrements, on transfer of the last word.
  - rd_data and rd_last stay stable while rd_valid=1 and rd_ready=0.
- Pointers wrap modulo FIFO_DEPTH. level counts from 0 to FIFO_DEPTH; a push and a pop in the same cycle leave level unchanged.
- resetn asserted mid-run aborts the run: FIFO flushed, overflow cleared, FSM=IDLE.

Optional Feature:
- Macro: DSP_CAPTURE_TIMESTAMP_EN.
- Defined:
  - A 32-bit cycle counter is cleared on the accepted start and increments every cycle (wraps at 2^32).
  - Each entry stores the counter value at its push.
  - The entry is read as 3 words: low, high, timestamp. rd_last is asserted on the timestamp word only.
  - Reading the three words as a group, the first sample with SETTLE_CYCLES=0 reads timestamp 1.
- Not defined: 2-word entries, no counter logic.

Test Plan:
- Basic run: SETTLE_CYCLES=0, CAPTURE_LEN=1, product held at 0x00000000011FDB31 (0x12345*0xFD), start pulse, rd_ready=1 -> words 0x011FDB31 (rd_last=0) then 0x00000000 (rd_last=1); done pulses once; level returns to 0.
- Chain propagation: product = 0 until cycle 3 after start, then 0x8 -> SETTLE_CYCLES=0, CAPTURE_LEN=6 gives entries 0,0,0,8,8,8 in that order.
- Overflow: FIFO_DEPTH=4, CAPTURE_LEN=6, rd_ready=0 -> level saturates at 4, overflow=1, first 4 samples retained in order. clr_overflow -> overflow=0.
- Backpressure: toggle rd_ready every other cycle -> rd_data stable while stalled, no word lost or duplicated over 8 entries.
- Simultaneous push/pop at full: FIFO full, rd_ready=1 on the high word in the same cycle as a push -> push accepted, level stays 4, overflow stays 0.
- Reset mid-capture: pull resetn low during CAPTURE cycle 2 -> busy=0, rd_valid=0, level=0 immediately; a new start afterwards yields a full CAPTURE_LEN run.
